// File: rtl/adsr_envelope_pkg.sv
// Shared definitions for the ADSR envelope stage.
//   adsr_state_e : FSM state encoding, also exported on the 'state' port
//   ENV_W/WAVE_W : default envelope / sample widths
//   ENV_FULL     : full-scale envelope (approximately unity gain)
package adsr_envelope_pkg;

    localparam int WAVE_W = 21;
    localparam int ENV_W  = 16;

    localparam logic [ENV_W-1:0] ENV_FULL = {ENV_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_e;

endpackage

// File: rtl/adsr_scale_pipe.sv
// Two-stage signed multiply/shift applying the envelope gain to a sample.
//   clk, rst_n : clock, async active-low reset (clears valid pipe and data)
//   in_wave    : signed sample, captured on in_valid
//   in_valid   : one-cycle sample strobe
//   env        : unsigned gain sampled alongside in_wave
//   out_wave   : floor((in_wave * env) / 2^ENV_WIDTH), holds between strobes
//   out_valid  : strobe two clocks after in_valid
module adsr_scale_pipe #(
    parameter int WAVE_WIDTH = 21,
    parameter int ENV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WAVE_WIDTH-1:0] in_wave,
    input  logic                  in_valid,
    input  logic [ENV_WIDTH-1:0]  env,
    output logic [WAVE_WIDTH-1:0] out_wave,
    output logic                  out_valid
);

    // Product width: signed sample times a zero-extended (always positive) gain.
    localparam int PW  = WAVE_WIDTH + ENV_WIDTH + 1;
    localparam int LAT = 2;

    logic signed [PW-1:0] wave_x, env_x, prod_q;
    logic [LAT-1:0]       vld_pipe;

    assign wave_x = {{(ENV_WIDTH + 1){in_wave[WAVE_WIDTH-1]}}, in_wave};
    assign env_x  = {{(WAVE_WIDTH + 1){1'b0}}, env};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            prod_q   <= '0;
            out_wave <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
            if (in_valid)
                prod_q <= wave_x * env_x;
            // Arithmetic shift by ENV_WIDTH then truncate: floor rounding.
            // The gain is below 1, so the kept bits cannot overflow.
            if (vld_pipe[0])
                out_wave <= prod_q[ENV_WIDTH +: WAVE_WIDTH];
        end
    end

    assign out_valid = vld_pipe[LAT-1];

    // Fraction bits and the redundant sign bit are dropped by the shift.
    logic [ENV_WIDTH:0] unused_prod;
    assign unused_prod = {prod_q[PW-1], prod_q[ENV_WIDTH-1:0]};

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope following the NCO. The envelope steps once per
// input sample; the sample is scaled by the envelope value held in the
// cycle it arrives (pre-update), with two clocks of latency.
//   clk, rst_n     : clock, async active-low reset
//   gate           : note on level; rising edge -> ATTACK, falling -> RELEASE
//   attack_step    : per-sample increment in ATTACK (0 = instant)
//   decay_step     : per-sample decrement in DECAY (0 = instant)
//   sustain_level  : SUSTAIN target, tracked live
//   release_step   : per-sample decrement in RELEASE (0 = instant)
//   in_wave/valid  : signed sample and strobe from the NCO
//   out_wave/valid : scaled sample and strobe
//   env, state     : current envelope value and FSM state
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int WAVE_WIDTH = WAVE_W,
    parameter int ENV_WIDTH  = ENV_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  gate,
    input  logic [ENV_WIDTH-1:0]  attack_step,
    input  logic [ENV_WIDTH-1:0]  decay_step,
    input  logic [ENV_WIDTH-1:0]  sustain_level,
    input  logic [ENV_WIDTH-1:0]  release_step,
    input  logic [WAVE_WIDTH-1:0] in_wave,
    input  logic                  in_valid,
    output logic [WAVE_WIDTH-1:0] out_wave,
    output logic                  out_valid,
    output logic [ENV_WIDTH-1:0]  env,
    output logic [2:0]            state
);

    localparam logic [ENV_WIDTH-1:0] FULL = {ENV_WIDTH{1'b1}};

    adsr_state_e          state_q, state_d;
    logic [ENV_WIDTH-1:0] env_q, env_d;
    logic                 gate_q;
    logic                 gate_rise, gate_fall;
    logic [ENV_WIDTH:0]   att_sum, dec_diff;

    assign gate_rise = gate & ~gate_q;
    assign gate_fall = ~gate & gate_q;

    // One extra bit so the attack sum cannot wrap and a decay step larger
    // than env shows up as a borrow.
    assign att_sum  = {1'b0, env_q} + {1'b0, attack_step};
    assign dec_diff = {1'b0, env_q} - {1'b0, decay_step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            env_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            gate_q  <= gate;
        end
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        // Gate edges win over a coincident sample: state moves, env holds.
        // A retrigger keeps the current env so attack continues from it.
        if (gate_rise) begin
            state_d = ATTACK;
        end else if (gate_fall) begin
            if (state_q != IDLE)
                state_d = RELEASE;
        end else if (in_valid) begin
            case (state_q)
                IDLE: env_d = '0;
                ATTACK: begin
                    if (attack_step == '0 || att_sum >= {1'b0, FULL}) begin
                        env_d   = FULL;
                        state_d = DECAY;
                    end else begin
                        env_d = att_sum[ENV_WIDTH-1:0];
                    end
                end
                DECAY: begin
                    // Also snaps upward if sustain was raised above env.
                    if (decay_step == '0 || env_q <= sustain_level ||
                        dec_diff[ENV_WIDTH] ||
                        dec_diff[ENV_WIDTH-1:0] <= sustain_level) begin
                        env_d   = sustain_level;
                        state_d = SUSTAIN;
                    end else begin
                        env_d = dec_diff[ENV_WIDTH-1:0];
                    end
                end
                SUSTAIN: env_d = sustain_level;
                RELEASE: begin
                    if (release_step == '0 || env_q <= release_step) begin
                        env_d   = '0;
                        state_d = IDLE;
                    end else begin
                        env_d = env_q - release_step;
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign env   = env_q;
    assign state = state_q;

    adsr_scale_pipe #(
        .WAVE_WIDTH (WAVE_WIDTH),
        .ENV_WIDTH  (ENV_WIDTH)
    ) u_scale (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_wave   (in_wave),
        .in_valid  (in_valid),
        .env       (env_q),
        .out_wave  (out_wave),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: stimulus pushes the hand-computed scaled
// sample into a scoreboard queue; a monitor pops and compares on out_valid.
module tb_adsr_envelope;
    import adsr_envelope_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gate;
    logic [15:0] attack_step, decay_step, sustain_level, release_step;
    logic [20:0] in_wave;
    logic        in_valid;
    logic [20:0] out_wave;
    logic        out_valid;
    logic [15:0] env;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;
    logic [20:0] sb[$];

    always #5 clk = ~clk;

    adsr_envelope dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .in_wave       (in_wave),
        .in_valid      (in_valid),
        .out_wave      (out_wave),
        .out_valid     (out_valid),
        .env           (env),
        .state         (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious out_valid", 32'(out_valid), 32'd0);
            end else begin
                logic [20:0] e;
                e = sb.pop_front();
                chk("out_wave", 32'(out_wave), 32'(e));
            end
        end
    end

    // One clock: present inputs, push expected output when valid, then
    // check the post-edge envelope and state.
    task automatic tick(input logic v, input logic [20:0] w, input logic [20:0] exp_out,
                        input logic [15:0] exp_env, input adsr_state_e exp_st,
                        input string name);
        in_valid = v;
        in_wave  = w;
        if (v) sb.push_back(exp_out);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({name, " env"}, 32'(env), 32'(exp_env));
        chk({name, " state"}, 32'(state), 32'(exp_st));
    endtask

    initial begin
        rst_n         = 1'b0;
        gate          = 1'b1;
        in_valid      = 1'b0;
        in_wave       = '0;
        attack_step   = 16'h4000;
        decay_step    = 16'h1000;
        sustain_level = 16'hC000;
        release_step  = 16'h8000;

        // Reset held with gate high and in_valid toggling.
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            in_wave  = 21'h0FFFFF;
            @(posedge clk);
            #1;
            chk("rst out_wave", 32'(out_wave), 32'd0);
            chk("rst out_valid", 32'(out_valid), 32'd0);
            chk("rst env", 32'(env), 32'd0);
            chk("rst state", 32'(state), 32'(IDLE));
        end
        in_valid = 1'b0;
        gate     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(1, 21'h000123, 21'h000000, 16'h0000, IDLE, "idle");

        // Attack from 0, with scaling points on each sample.
        gate = 1'b1;
        tick(0, 21'h0, 21'h0, 16'h0000, ATTACK, "gate rise");
        tick(1, 21'h0FFFFF, 21'h000000, 16'h4000, ATTACK, "att1");
        tick(1, 21'h000400, 21'h000100, 16'h8000, ATTACK, "att2");
        tick(1, 21'h100000, 21'h180000, 16'hC000, ATTACK, "att3");
        tick(1, 21'h1FFFFF, 21'h1FFFFF, ENV_FULL, DECAY, "att4");

        // Decay to sustain.
        tick(1, 21'h0FFFFF, 21'h0FFFEF, 16'hEFFF, DECAY, "dec1");
        tick(1, 21'h000000, 21'h000000, 16'hDFFF, DECAY, "dec2");
        tick(1, 21'h000000, 21'h000000, 16'hCFFF, DECAY, "dec3");
        tick(1, 21'h000000, 21'h000000, 16'hC000, SUSTAIN, "dec4");
        tick(1, 21'h000000, 21'h000000, 16'hC000, SUSTAIN, "sus");
        sustain_level = 16'hA000;
        tick(1, 21'h000000, 21'h000000, 16'hA000, SUSTAIN, "sus track");
        sustain_level = 16'hC000;
        tick(1, 21'h000000, 21'h000000, 16'hC000, SUSTAIN, "sus back");

        // Release to idle.
        gate = 1'b0;
        tick(0, 21'h0, 21'h0, 16'hC000, RELEASE, "gate fall");
        tick(1, 21'h000000, 21'h000000, 16'h4000, RELEASE, "rel1");
        tick(1, 21'h000000, 21'h000000, 16'h0000, IDLE, "rel2");

        // Attack/decay again, then retrigger during release.
        gate = 1'b1;
        tick(0, 21'h0, 21'h0, 16'h0000, ATTACK, "rise2");
        tick(1, 21'h000000, 21'h000000, 16'h4000, ATTACK, "b_att1");
        tick(1, 21'h000000, 21'h000000, 16'h8000, ATTACK, "b_att2");
        tick(1, 21'h000000, 21'h000000, 16'hC000, ATTACK, "b_att3");
        tick(1, 21'h000000, 21'h000000, ENV_FULL, DECAY, "b_att4");
        tick(1, 21'h000000, 21'h000000, 16'hEFFF, DECAY, "b_dec1");
        tick(1, 21'h000000, 21'h000000, 16'hDFFF, DECAY, "b_dec2");
        tick(1, 21'h000000, 21'h000000, 16'hCFFF, DECAY, "b_dec3");
        tick(1, 21'h000000, 21'h000000, 16'hC000, SUSTAIN, "b_dec4");
        gate = 1'b0;
        tick(0, 21'h0, 21'h0, 16'hC000, RELEASE, "fall2");
        tick(1, 21'h000000, 21'h000000, 16'h4000, RELEASE, "b_rel1");
        // Rise coincident with a sample: state changes, env holds 0x4000,
        // and that sample is scaled by 0x4000.
        gate = 1'b1;
        tick(1, 21'h000400, 21'h000100, 16'h4000, ATTACK, "retrig coinc");
        tick(1, 21'h000000, 21'h000000, 16'h8000, ATTACK, "retrig att");

        // All steps zero: instant transitions.
        attack_step  = 16'h0;
        decay_step   = 16'h0;
        release_step = 16'h0;
        gate = 1'b0;
        tick(0, 21'h0, 21'h0, 16'h8000, RELEASE, "z fall");
        tick(1, 21'h000000, 21'h000000, 16'h0000, IDLE, "z rel");
        gate = 1'b1;
        tick(0, 21'h0, 21'h0, 16'h0000, ATTACK, "z rise");
        tick(1, 21'h000000, 21'h000000, ENV_FULL, DECAY, "z att");
        tick(1, 21'h000000, 21'h000000, 16'hC000, SUSTAIN, "z dec");
        gate = 1'b0;
        tick(0, 21'h0, 21'h0, 16'hC000, RELEASE, "z fall2");
        tick(1, 21'h0FFFFF, 21'h0BFFFF, 16'h0000, IDLE, "z rel2");

        // Reset pulse between in_valid and out_valid: the sample is dropped.
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_wave  = 21'h0FFFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post-rst env", 32'(env), 32'd0);
        chk("post-rst state", 32'(state), 32'(IDLE));
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
